// File: rtl/scarv_cop_pmul_iter.sv
`default_nettype none
// ============================================================================
// Module   : scarv_cop_pmul_iter
// Purpose  : Iterative packed multiplier (integer or carry-less), one
//            multiplier bit per lane per cycle, for the pmul/pclmul classes.
// Revision : 1.0 - initial release
// ============================================================================
module scarv_cop_pmul_iter (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        start,
    output logic        done,
    output logic        busy,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  pw,
    input  logic        high,
    input  logic        ncarry,
    output logic [31:0] result
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [63:0] r_acc;
    logic [4:0]  r_count;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_sel;
    logic        r_high;
    logic        r_ncarry;

    logic [2:0]  w_sel_in;
    logic        w_last;
    logic [63:0] w_acc_nxt;
    logic [31:0] w_lo;
    logic [31:0] w_hi;

    logic [63:0] w_acc_cand [5];
    logic [31:0] w_lo_cand  [5];
    logic [31:0] w_hi_cand  [5];

    // Width select: 0..4 for 32/16/8/4/2-bit lanes; unknown encodings act as 1x32.
    always_comb begin
        w_sel_in = 3'd0;
        case (pw)
            3'b010:  w_sel_in = 3'd1;
            3'b011:  w_sel_in = 3'd2;
            3'b100:  w_sel_in = 3'd3;
            3'b101:  w_sel_in = 3'd4;
            default: w_sel_in = 3'd0;
        endcase
    end

    assign w_last = (r_count == (5'd31 >> r_sel));

    genvar gi, gk;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_width
            localparam int c_lw = 32 >> gi;
            localparam int c_nl = 32 / c_lw;
            localparam int c_cw = $clog2(c_lw);

            logic [63:0] w_acc_w;
            logic [31:0] w_lo_w;
            logic [31:0] w_hi_w;

            for (gk = 0; gk < c_nl; gk++) begin : g_lane
                logic [c_lw-1:0]   w_op_a;
                logic [c_lw-1:0]   w_op_b;
                logic [2*c_lw-1:0] w_lane;
                logic [2*c_lw-1:0] w_pp;

                assign w_op_a = r_a[gk*c_lw +: c_lw];
                assign w_op_b = r_b[gk*c_lw +: c_lw];
                assign w_lane = r_acc[gk*2*c_lw +: 2*c_lw];
                assign w_pp   = w_op_b[r_count[c_cw-1:0]]
                              ? ({{c_lw{1'b0}}, w_op_a} << r_count[c_cw-1:0])
                              : '0;
                // Lane-local add or XOR: carries never cross into the next lane.
                assign w_acc_w[gk*2*c_lw +: 2*c_lw] = r_ncarry ? (w_lane ^ w_pp)
                                                               : (w_lane + w_pp);
                assign w_lo_w[gk*c_lw +: c_lw] = w_lane[c_lw-1:0];
                assign w_hi_w[gk*c_lw +: c_lw] = w_lane[2*c_lw-1:c_lw];
            end

            assign w_acc_cand[gi] = w_acc_w;
            assign w_lo_cand[gi]  = w_lo_w;
            assign w_hi_cand[gi]  = w_hi_w;
        end
    endgenerate

    always_comb begin
        w_acc_nxt = w_acc_cand[0];
        w_lo      = w_lo_cand[0];
        w_hi      = w_hi_cand[0];
        case (r_sel)
            3'd1: begin
                w_acc_nxt = w_acc_cand[1];
                w_lo      = w_lo_cand[1];
                w_hi      = w_hi_cand[1];
            end
            3'd2: begin
                w_acc_nxt = w_acc_cand[2];
                w_lo      = w_lo_cand[2];
                w_hi      = w_hi_cand[2];
            end
            3'd3: begin
                w_acc_nxt = w_acc_cand[3];
                w_lo      = w_lo_cand[3];
                w_hi      = w_hi_cand[3];
            end
            3'd4: begin
                w_acc_nxt = w_acc_cand[4];
                w_lo      = w_lo_cand[4];
                w_hi      = w_hi_cand[4];
            end
            default: begin
                w_acc_nxt = w_acc_cand[0];
                w_lo      = w_lo_cand[0];
                w_hi      = w_hi_cand[0];
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run: begin
                if (!start)     w_state_nxt = c_st_idle;
                else if (w_last) w_state_nxt = c_st_done;
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_high   <= 1'b0;
            r_ncarry <= 1'b0;
        end else if (r_state == c_st_idle && start) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_a      <= a;
            r_b      <= b;
            r_sel    <= w_sel_in;
            r_high   <= high;
            r_ncarry <= ncarry;
        end else if (r_state == c_st_run && start) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + 5'd1;
        end
    end

    assign done   = (r_state == c_st_done);
    assign busy   = (r_state != c_st_idle);
    assign result = done ? (r_high ? w_hi : w_lo) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_scarv_cop_pmul_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_scarv_cop_pmul_iter
// Purpose  : Directed and randomized self-checking bench with a lane-wise
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scarv_cop_pmul_iter;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        busy;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  pw = 3'b001;
    logic        high = 1'b0;
    logic        ncarry = 1'b0;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    scarv_cop_pmul_iter dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .start    (start),
        .done     (done),
        .busy     (busy),
        .a        (a),
        .b        (b),
        .pw       (pw),
        .high     (high),
        .ncarry   (ncarry),
        .result   (result)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lane_w(input logic [2:0] p);
        case (p)
            3'b010:  return 16;
            3'b011:  return 8;
            3'b100:  return 4;
            3'b101:  return 2;
            default: return 32;
        endcase
    endfunction

    // Full-width product per lane, then pick the requested half.
    function automatic logic [31:0] model(input logic [31:0] x_in, input logic [31:0] y_in,
                                          input logic [2:0] p, input logic h, input logic nc);
        int w = lane_w(p);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned r = 0;
        for (int k = 0; k < 32 / w; k++) begin
            longint unsigned x = (longint'(x_in) >> (k * w)) & mask;
            longint unsigned y = (longint'(y_in) >> (k * w)) & mask;
            longint unsigned prod = 0;
            longint unsigned lane;
            if (nc) begin
                for (int j = 0; j < w; j++)
                    if ((y >> j) & 64'd1) prod = prod ^ (x << j);
            end else begin
                prod = x * y;
            end
            lane = h ? ((prod >> w) & mask) : (prod & mask);
            r = r | (lane << (k * w));
        end
        return r[31:0];
    endfunction

    // Issue one op, scramble inputs mid-run, check latency/result/busy.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] pv,
                          input logic hv, input logic nv, input logic [31:0] exp,
                          input string tag);
        int lat = 0;
        logic early_res = 1'b0;
        @(negedge g_clk);
        a = av; b = bv; pw = pv; high = hv; ncarry = nv; start = 1'b1;
        @(posedge g_clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge g_clk);
            if (c == 1) check({tag, ".busy"}, {31'd0, busy}, 32'd1);
            if (c == 2) begin
                a = $urandom; b = $urandom; pw = 3'($urandom); high = ~hv; ncarry = ~nv;
            end
            if (done) begin
                lat = c;
                break;
            end
            if (result !== 32'd0) early_res = 1'b1;
        end
        check({tag, ".lat"}, lat, lane_w(pv) + 1);
        check({tag, ".res"}, result, exp);
        check({tag, ".res0"}, {31'd0, early_res}, 32'd0);
        start = 1'b0;
        @(negedge g_clk);
        check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        int lat1;
        int lat2;
        logic between_nz;
        logic [31:0] ra, rb, e1, e2;
        logic [2:0] rp;
        logic rh, rn;

        repeat (3) @(negedge g_clk);
        check("reset.outs", {result[29:0], busy, done}, 32'd0);
        g_resetn = 1'b1;

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 1'b0, 1'b0, 32'h00000001, "t1.lo");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 1'b1, 1'b0, 32'hFFFFFFFE, "t1.hi");
        run_op(32'h0003FFFF, 32'h0005FFFF, 3'b010, 1'b0, 1'b0, 32'h000F0001, "t2.lo");
        run_op(32'h0003FFFF, 32'h0005FFFF, 3'b010, 1'b1, 1'b0, 32'h0000FFFE, "t2.hi");
        run_op(32'h03030303, 32'h03030303, 3'b011, 1'b0, 1'b1, 32'h05050505, "t3.clmul");
        run_op(32'h03030303, 32'h03030303, 3'b011, 1'b0, 1'b0, 32'h09090909, "t3.mul");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 1'b0, 1'b0, 32'h55555555, "t4.lo");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 1'b1, 1'b0, 32'hAAAAAAAA, "t4.hi");

        // Abort mid-run: no done, back to idle after one edge.
        @(negedge g_clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; pw = 3'b001; high = 1'b0; ncarry = 1'b0;
        start = 1'b1;
        @(posedge g_clk);
        repeat (10) @(negedge g_clk);
        start = 1'b0;
        @(negedge g_clk);
        check("abort.busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge g_clk);
            if (done) pulses++;
        end
        check("abort.nodone", pulses, 0);
        run_op(32'd7, 32'd6, 3'b001, 1'b0, 1'b0, 32'd42, "abort.restart");

        // Reset during RUN.
        @(negedge g_clk);
        a = 32'h12345678; b = 32'h9ABCDEF0; pw = 3'b011; start = 1'b1;
        @(posedge g_clk);
        repeat (3) @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        check("rst.run", {result[29:0], busy, done}, 32'd0);
        start = 1'b0;
        g_resetn = 1'b1;
        @(negedge g_clk);
        check("rst.idle", {31'd0, busy}, 32'd0);

        // Back-to-back with start held: 4x8 then 8x4.
        ra = $urandom; rb = $urandom;
        e1 = model(ra, rb, 3'b011, 1'b0, 1'b0);
        @(negedge g_clk);
        a = ra; b = rb; pw = 3'b011; high = 1'b0; ncarry = 1'b0; start = 1'b1;
        @(posedge g_clk);
        pulses = 0; lat1 = 0; lat2 = 0; between_nz = 1'b0; e2 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge g_clk);
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    lat1 = c;
                    check("b2b.res1", result, e1);
                    ra = $urandom; rb = $urandom;
                    e2 = model(ra, rb, 3'b100, 1'b1, 1'b1);
                    a = ra; b = rb; pw = 3'b100; high = 1'b1; ncarry = 1'b1;
                end else begin
                    lat2 = c;
                    check("b2b.res2", result, e2);
                    start = 1'b0;
                    break;
                end
            end else if (pulses == 1 && result !== 32'd0) begin
                between_nz = 1'b1;
            end
        end
        check("b2b.lat1", lat1, 9);
        check("b2b.lat2", lat2, 15);
        check("b2b.between", {31'd0, between_nz}, 32'd0);
        repeat (20) begin
            @(negedge g_clk);
            if (done) pulses++;
        end
        check("b2b.pulses", pulses, 2);

        // Randomized ops, including unused pw encodings.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom;
            rp = 3'($urandom_range(0, 7));
            rh = 1'($urandom); rn = 1'($urandom);
            run_op(ra, rb, rp, rh, rn, model(ra, rb, rp, rh, rn), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
